pe_sequencer: RTL and testbench

Drives one proElement through a full dense layer: for each neuron it fetches bias, weights and inputs from on-chip read memories and streams them into the PE behind a head pulse. It then waits for done_flag and writes pe_out into the result buffer.
It is the initiator/feeder end of the proElement w/x/b/count/head -> pe_out/done_flag interface and sits between the layer memories and the PE in the MNIST accelerator datapath.

---
 rtl/pe_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pe_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sequencer.sv
// pe_sequencer: feeds one proElement through a full dense layer.
// For each neuron it reads the bias, the weights and the inputs from 1-cycle-latency
// memories. It streams them into the PE behind a head pulse, waits for pe_done_flag,
// and writes pe_out to the result buffer at address n.
//
// Optional build macro: PE_TIMEOUT_EN adds a WAIT watchdog. A neuron whose PE never
// answers gets a quiet NaN result and sets the sticky err flag.
//
// Ports:
//   clock, rst_n        clock (rising edge), asynchronous active-low reset
//   start / busy / done layer request, in-progress flag, one-cycle completion pulse
//   w_addr / w_rdata    weight memory read port (index n*N_INPUTS + i)
//   x_addr / x_rdata    activation memory read port (index i)
//   b_addr / b_rdata    bias memory read port (index n)
//   pe_w/pe_x/pe_b      element stream to the PE, with pe_count and pe_head
//   pe_out/pe_done_flag PE result and result-valid pulse
//   res_we/addr/data    result buffer write port
//   err                 sticky watchdog flag (constant 0 without PE_TIMEOUT_EN)
module pe_sequencer #(
  parameter int N_INPUTS  = 784,
  parameter int N_NEURONS = 10,
  parameter int W_AW      = 13,
  parameter int X_AW      = 10,
  parameter int N_AW      = 4,
  parameter int TIMEOUT   = 2047
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [W_AW-1:0] w_addr,
  input  logic [31:0]     w_rdata,
  output logic [X_AW-1:0] x_addr,
  input  logic [31:0]     x_rdata,
  output logic [N_AW-1:0] b_addr,
  input  logic [31:0]     b_rdata,
  output logic [31:0]     pe_w,
  output logic [31:0]     pe_x,
  output logic [31:0]     pe_b,
  output logic [9:0]      pe_count,
  output logic            pe_head,
  input  logic [31:0]     pe_out,
  input  logic            pe_done_flag,
  output logic            res_we,
  output logic [N_AW-1:0] res_addr,
  output logic [31:0]     res_data,
  output logic            err
);

  if (N_INPUTS < 1 || N_INPUTS > 1023 || N_NEURONS < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("pe_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, WAIT, WRITE, FINISH} state_t;

  localparam logic [9:0]      LAST_I = 10'(N_INPUTS - 1);
  localparam logic [N_AW-1:0] LAST_N = N_AW'(N_NEURONS - 1);
  localparam logic [W_AW-1:0] W_STEP = W_AW'(N_INPUTS);

  state_t          state;
  logic [9:0]      idx;   // element index inside STREAM
  logic [N_AW-1:0] n;     // neuron index
  logic [W_AW-1:0] wb;    // weight base of the current neuron (running sum, no multiply)

  assign pe_count = 10'(N_INPUTS);

`ifdef PE_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pe_head  <= 1'b0;
      res_we   <= 1'b0;
      w_addr   <= '0;
      x_addr   <= '0;
      b_addr   <= '0;
      pe_w     <= '0;
      pe_x     <= '0;
      pe_b     <= '0;
      res_addr <= '0;
      res_data <= '0;
      idx      <= '0;
      n        <= '0;
      wb       <= '0;
`ifdef PE_TIMEOUT_EN
      tcnt     <= '0;
      err      <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      pe_head <= 1'b0;
      res_we  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= FETCH;
          busy   <= 1'b1;
          n      <= '0;
          wb     <= '0;
          b_addr <= '0;
          w_addr <= '0;
          x_addr <= '0;
`ifdef PE_TIMEOUT_EN
          err    <= 1'b0;
`endif
        end
        FETCH: begin
          // Addresses were set on entry; from here on they lead the registered data by one.
          state  <= STREAM;
          idx    <= '0;
          w_addr <= w_addr + 1'b1;
          x_addr <= x_addr + 1'b1;
        end
        STREAM: begin
          pe_w   <= w_rdata;
          pe_x   <= x_rdata;
          w_addr <= w_addr + 1'b1;
          x_addr <= x_addr + 1'b1;
          idx    <= idx + 1'b1;
          if (idx == '0) begin
            pe_b    <= b_rdata;
            pe_head <= 1'b1;     // lands at the PE together with element 0
          end
          if (idx == LAST_I) begin
            state <= WAIT;
`ifdef PE_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        end
        WAIT: begin
          if (pe_done_flag) begin
            res_data <= pe_out;
            res_we   <= 1'b1;
            res_addr <= n;
            state    <= WRITE;
          end
`ifdef PE_TIMEOUT_EN
          else if (tcnt == T_LAST) begin
            res_data <= 32'h7FC0_0000;
            res_we   <= 1'b1;
            res_addr <= n;
            err      <= 1'b1;
            state    <= WRITE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        WRITE: begin
          if (n == LAST_N) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state  <= FETCH;
            n      <= n + 1'b1;
            wb     <= wb + W_STEP;
            b_addr <= n + 1'b1;
            w_addr <= wb + W_STEP;
            x_addr <= '0;
          end
        end
        FINISH: state <= IDLE;   // start here is dropped
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: lane 0 is a 4-input/2-neuron layer, lane 1 a 1-input/1-neuron layer.
// Each lane has its own memories and a behavioural PE that accumulates b + sum(w*x)
// from what it sees on the stream.
module tb_pe_sequencer;
  logic clock = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;
  always_ff @(posedge clock) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'h00) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real  a;
    int   e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ln
    localparam int NI = (g == 0) ? 4 : 1;
    localparam int NN = (g == 0) ? 2 : 1;
    logic        start, busy, done, pe_head, pe_done_flag, res_we, err;
    logic [12:0] w_addr;
    logic [9:0]  x_addr, pe_count;
    logic [3:0]  b_addr, res_addr;
    logic [31:0] w_rdata, x_rdata, b_rdata, pe_w, pe_x, pe_b, pe_out, res_data;
    logic [31:0] wmem [16];
    logic [31:0] xmem [16];
    logic [31:0] bmem [16];
    int          lat, mute_head;
    bit          spur;
    int          heads, dones, wait_start;
    int          wr_cnt [16];
    int          gap [16];
    logic [31:0] res [16];

    pe_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .W_AW(13), .X_AW(10), .N_AW(4), .TIMEOUT(16)) dut (
      .clock(clock), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .w_addr(w_addr), .w_rdata(w_rdata), .x_addr(x_addr), .x_rdata(x_rdata),
      .b_addr(b_addr), .b_rdata(b_rdata), .pe_w(pe_w), .pe_x(pe_x), .pe_b(pe_b),
      .pe_count(pe_count), .pe_head(pe_head), .pe_out(pe_out), .pe_done_flag(pe_done_flag),
      .res_we(res_we), .res_addr(res_addr), .res_data(res_data), .err(err));

    always_ff @(posedge clock) begin
      w_rdata <= (w_addr < 13'd16) ? wmem[w_addr[3:0]] : 32'hDEAD_BEEF;
      x_rdata <= (x_addr < 10'd16) ? xmem[x_addr[3:0]] : 32'hDEAD_BEEF;
      b_rdata <= bmem[b_addr];
    end

    // PE model and result monitor, both working on negedge-stable values.
    initial begin : model
      real acc;
      int  k, pend;
      k = 0; pend = -1; acc = 0.0; heads = 0; dones = 0; wait_start = 0;
      pe_done_flag = 1'b0; pe_out = '0;
      for (int i = 0; i < 16; i++) begin wr_cnt[i] = 0; gap[i] = 0; res[i] = '0; end
      forever begin
        @(negedge clock);
        pe_done_flag = 1'b0;
        if (!rst_n) begin
          k = 0; pend = -1;
        end else begin
          if (res_we) begin
            res[res_addr] = res_data;
            wr_cnt[res_addr]++;
            gap[res_addr] = cyc - wait_start;
          end
          if (done) dones++;
          if (pend > 0) begin
            pend--;
            if (pend == 0) begin pe_done_flag = 1'b1; pe_out = r2f(acc); pend = -1; end
          end
          if (pe_head) begin
            heads++;
            acc = f2r(pe_b) + f2r(pe_w) * f2r(pe_x);
            k = 1;
          end else if (k > 0 && k < NI) begin
            acc = acc + f2r(pe_w) * f2r(pe_x);
            k++;
          end
          if (k == NI) begin
            k = 0;
            wait_start = cyc;
            if (heads != mute_head) pend = lat;
          end else if (spur && k > 0) begin
            pe_done_flag = 1'b1;        // stray pulse while streaming: must be ignored
            pe_out = 32'hDEAD_BEEF;
          end
        end
      end
    end
  end

  typedef struct {
    logic [31:0] w, x, b0, b1;
    int          lat;
    bit          poke;
    logic [31:0] e0, e1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start0();
    @(negedge clock); ln[0].start = 1'b1;
    @(negedge clock); ln[0].start = 1'b0;
  endtask

  task automatic wait_head0(output bit hit);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clock);
      if (ln[0].pe_head) hit = 1'b1;
    end
  endtask

  task automatic wait_done0(output bit hit);
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clock);
      if (ln[0].done) hit = 1'b1;
    end
  endtask

  // Runs one lane-0 layer with uniform w/x and per-neuron bias; checks results and pulse counts.
  task automatic run_vec(input vec_t v, input string tag);
    int h0, d0, c0, c1;
    bit hit;
    for (int i = 0; i < 8; i++) ln[0].wmem[i] = v.w;
    for (int i = 0; i < 4; i++) ln[0].xmem[i] = v.x;
    ln[0].bmem[0] = v.b0; ln[0].bmem[1] = v.b1; ln[0].lat = v.lat;
    h0 = ln[0].heads; d0 = ln[0].dones; c0 = ln[0].wr_cnt[0]; c1 = ln[0].wr_cnt[1];
    start0();
    if (v.poke) begin
      wait_head0(hit);
      chk({tag, "_poke_head"}, 32'(hit), 32'd1);
      ln[0].start = 1'b1; @(negedge clock); ln[0].start = 1'b0;
    end
    wait_done0(hit);
    chk({tag, "_done_seen"}, 32'(hit), 32'd1);
    ln[0].start = 1'b1; @(negedge clock); ln[0].start = 1'b0;   // start during FINISH
    chk({tag, "_finish_start_dropped"}, 32'(ln[0].busy), 32'd0);
    @(negedge clock);
    chk({tag, "_res0"}, ln[0].res[0], v.e0);
    chk({tag, "_res1"}, ln[0].res[1], v.e1);
    chk({tag, "_writes"}, 32'((ln[0].wr_cnt[0] - c0) * 16 + (ln[0].wr_cnt[1] - c1)), 32'h11);
    chk({tag, "_heads"}, 32'(ln[0].heads - h0), 32'd2);
    chk({tag, "_dones"}, 32'(ln[0].dones - d0), 32'd1);
  endtask

  initial begin : main
    vec_t        tbl [5];
    logic [31:0] vals [8];
    bit          hit;
    int          h0, d0, c0, c1;
    real         acc;
    logic [31:0] e [2];

    rst_n = 1'b0;
    for (int g = 0; g < 16; g++) begin
      ln[0].wmem[g] = '0; ln[0].xmem[g] = '0; ln[0].bmem[g] = '0;
      ln[1].wmem[g] = '0; ln[1].xmem[g] = '0; ln[1].bmem[g] = '0;
    end
    ln[0].start = 1'b0; ln[0].lat = 3; ln[0].spur = 1'b0; ln[0].mute_head = -1;
    ln[1].start = 1'b0; ln[1].lat = 2; ln[1].spur = 1'b0; ln[1].mute_head = -1;

    tbl[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0, 3, 1'b0, 32'h4100_0000, 32'h4100_0000};
    tbl[1] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h3F80_0000, 1, 1'b0, 32'h4090_0000, 32'h40A0_0000};
    tbl[2] = '{32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h0, 5, 1'b0, 32'h4040_0000, 32'h4080_0000};
    tbl[3] = '{32'h0, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 2, 1'b0, 32'h3F80_0000, 32'h4000_0000};
    tbl[4] = '{32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0, 3, 1'b1, 32'h4100_0000, 32'h4100_0000};
    vals = '{32'h0, 32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000,
             32'hBF80_0000, 32'hC000_0000, 32'h3E80_0000, 32'h4040_0000};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ctl", {27'b0, ln[0].busy, ln[0].done, ln[0].pe_head, ln[0].res_we, ln[0].err}, 32'h0);
    chk("rst_addr", {5'b0, ln[0].w_addr, ln[0].x_addr, ln[0].b_addr}, 32'h0);
    chk("rst_data", ln[0].pe_w | ln[0].pe_x | ln[0].pe_b | ln[0].res_data | 32'(ln[0].res_addr), 32'h0);
    chk("rst_count", 32'(ln[0].pe_count), 32'd4);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // Table vectors: basic layer, varied data/latency, start while busy
    foreach (tbl[v]) run_vec(tbl[v], $sformatf("vec%0d", v));

    // Stream timing: distinct weight/input words, distinct biases
    for (int i = 0; i < 8; i++) ln[0].wmem[i] = 32'(i);
    for (int i = 0; i < 4; i++) ln[0].xmem[i] = 32'(100 + i);
    ln[0].bmem[0] = 32'h3F80_0000; ln[0].bmem[1] = 32'h4000_0000; ln[0].lat = 2;
    start0();
    for (int nr = 0; nr < 2; nr++) begin
      wait_head0(hit);
      chk($sformatf("strm_head%0d", nr), 32'(hit), 32'd1);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("strm_w_n%0d_k%0d", nr, k), ln[0].pe_w, 32'(nr * 4 + k));
        chk($sformatf("strm_x_n%0d_k%0d", nr, k), ln[0].pe_x, 32'(100 + k));
        chk($sformatf("strm_b_n%0d_k%0d", nr, k), ln[0].pe_b, ln[0].bmem[nr]);
        chk($sformatf("strm_hd_n%0d_k%0d", nr, k), 32'(ln[0].pe_head), 32'(k == 0));
        if (k < 3) @(negedge clock);
      end
      chk("strm_count", 32'(ln[0].pe_count), 32'd4);
      @(negedge clock);
      chk($sformatf("strm_hold_w%0d", nr), ln[0].pe_w, 32'(nr * 4 + 3));
      chk($sformatf("strm_hold_b%0d", nr), ln[0].pe_b, ln[0].bmem[nr]);
    end
    wait_done0(hit);
    chk("strm_done", 32'(hit), 32'd1);
    @(negedge clock);

    // Reset in WAIT of neuron 1
    for (int i = 0; i < 8; i++) ln[0].wmem[i] = 32'h3F80_0000;
    for (int i = 0; i < 4; i++) ln[0].xmem[i] = 32'h4000_0000;
    ln[0].bmem[0] = 32'h0; ln[0].bmem[1] = 32'h0; ln[0].lat = 10;
    start0();
    wait_head0(hit);
    wait_head0(hit);
    chk("mid_head1", 32'(hit), 32'd1);
    repeat (5) @(negedge clock);
    c1 = ln[0].wr_cnt[1]; d0 = ln[0].dones;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {27'b0, ln[0].busy, ln[0].done, ln[0].pe_head, ln[0].res_we, ln[0].err}, 32'h0);
    chk("mid_rst_addr", {5'b0, ln[0].w_addr, ln[0].x_addr, ln[0].b_addr}, 32'h0);
    chk("mid_rst_data", ln[0].pe_w | ln[0].pe_x | ln[0].pe_b | ln[0].res_data, 32'h0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (15) @(negedge clock);
    chk("mid_no_write1", 32'(ln[0].wr_cnt[1] - c1), 32'd0);
    chk("mid_no_done", 32'(ln[0].dones - d0), 32'd0);
    chk("mid_idle", 32'(ln[0].busy), 32'd0);
    run_vec(tbl[0], "after_rst");

    // Edge size on lane 1: one input, one neuron
    ln[1].wmem[0] = 32'h3F80_0000; ln[1].xmem[0] = 32'h3F80_0000; ln[1].bmem[0] = 32'h3F00_0000;
    h0 = ln[1].heads; d0 = ln[1].dones; c0 = ln[1].wr_cnt[0];
    @(negedge clock); ln[1].start = 1'b1; @(negedge clock); ln[1].start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin @(negedge clock); if (ln[1].pe_head) hit = 1'b1; end
    chk("edge_head", 32'(hit), 32'd1);
    chk("edge_w", ln[1].pe_w, 32'h3F80_0000);
    chk("edge_x", ln[1].pe_x, 32'h3F80_0000);
    chk("edge_b", ln[1].pe_b, 32'h3F00_0000);
    chk("edge_count", 32'(ln[1].pe_count), 32'd1);
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin @(negedge clock); if (ln[1].done) hit = 1'b1; end
    chk("edge_done", 32'(hit), 32'd1);
    @(negedge clock);
    chk("edge_res", ln[1].res[0], 32'h3FC0_0000);
    chk("edge_writes", 32'(ln[1].wr_cnt[0] - c0), 32'd1);
    chk("edge_heads", 32'(ln[1].heads - h0), 32'd1);
    chk("edge_dones", 32'(ln[1].dones - d0), 32'd1);
    chk("edge_idle", 32'(ln[1].busy), 32'd0);

    // Randomized layers against a reference built directly from the memory contents
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) ln[0].wmem[i] = vals[$urandom_range(0, 7)];
      for (int i = 0; i < 4; i++) ln[0].xmem[i] = vals[$urandom_range(0, 7)];
      for (int i = 0; i < 2; i++) ln[0].bmem[i] = vals[$urandom_range(0, 7)];
      ln[0].lat = $urandom_range(1, 6);
      ln[0].spur = 1'($urandom_range(0, 1));
      for (int nr = 0; nr < 2; nr++) begin
        acc = f2r(ln[0].bmem[nr]);
        for (int i = 0; i < 4; i++) acc = acc + f2r(ln[0].wmem[nr * 4 + i]) * f2r(ln[0].xmem[i]);
        e[nr] = r2f(acc);
      end
      c0 = ln[0].wr_cnt[0]; c1 = ln[0].wr_cnt[1];
      start0();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) @(negedge clock);
        ln[0].start = 1'b1; @(negedge clock); ln[0].start = 1'b0;
      end
      wait_done0(hit);
      chk($sformatf("rnd%0d_done", r), 32'(hit), 32'd1);
      @(negedge clock);
      chk($sformatf("rnd%0d_res0", r), ln[0].res[0], e[0]);
      chk($sformatf("rnd%0d_res1", r), ln[0].res[1], e[1]);
      chk($sformatf("rnd%0d_writes", r), 32'((ln[0].wr_cnt[0] - c0) * 16 + (ln[0].wr_cnt[1] - c1)), 32'h11);
    end
    ln[0].spur = 1'b0;

`ifdef PE_TIMEOUT_EN
    // Watchdog: PE never answers neuron 0
    for (int i = 0; i < 8; i++) ln[0].wmem[i] = 32'h3F80_0000;
    for (int i = 0; i < 4; i++) ln[0].xmem[i] = 32'h4000_0000;
    ln[0].bmem[0] = 32'h0; ln[0].bmem[1] = 32'h0; ln[0].lat = 3;
    ln[0].mute_head = ln[0].heads + 1;
    start0();
    wait_done0(hit);
    chk("to_done", 32'(hit), 32'd1);
    @(negedge clock);
    ln[0].mute_head = -1;
    chk("to_res0", ln[0].res[0], 32'h7FC0_0000);
    chk("to_gap0", 32'(ln[0].gap[0]), 32'd16);
    chk("to_res1", ln[0].res[1], 32'h4100_0000);
    chk("to_err", 32'(ln[0].err), 32'd1);
    start0();
    chk("to_err_cleared", 32'(ln[0].err), 32'd0);
    wait_done0(hit);
    @(negedge clock);
`endif

    chk("err_lane0", 32'(ln[0].err), 32'd0);
    chk("err_lane1", 32'(ln[1].err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected one");
    $fatal(1, "time limit");
  end

endmodule
